// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   8N1 serial receiver for the MCL51 BIU console UART.  Each good byte goes
//   into a small first-word-fall-through FIFO.  Dropped bytes and bad stop bits
//   are reported through sticky error flags.
//
// Parameters
//   CLK_DIV         core clocks per bit (4 .. 65535)
//   FIFO_AW         log2 of the FIFO depth
//
// Ports
//   CORE_CLK        core clock, rising edge
//   RST             synchronous active-high reset
//   UART_RX         asynchronous serial input, idles high
//   RX_READ         one-cycle pop strobe (ignored while the FIFO is empty)
//   ERR_CLEAR       clears RX_OVERRUN and RX_FRAMING_ERR
//   RX_DATA         head-of-FIFO byte
//   RX_VALID        FIFO not empty
//   RX_COUNT        number of bytes held
//   RX_OVERRUN      sticky: a good byte was dropped because the FIFO was full
//   RX_FRAMING_ERR  sticky: a stop bit was sampled low
//   RX_BUSY         receive FSM is not idle (registered)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int CLK_DIV = 868,
   parameter int FIFO_AW = 2
) (
   input  logic               CORE_CLK,
   input  logic               RST,
   input  logic               UART_RX,
   input  logic               RX_READ,
   input  logic               ERR_CLEAR,
   output logic [7:0]         RX_DATA,
   output logic               RX_VALID,
   output logic [FIFO_AW:0]   RX_COUNT,
   output logic               RX_OVERRUN,
   output logic               RX_FRAMING_ERR,
   output logic               RX_BUSY
);

   localparam int               DEPTH     = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW+1)'(DEPTH);
   localparam logic [15:0]      HALF_BIT  = 16'(CLK_DIV/2 - 1);
   localparam logic [15:0]      FULL_BIT  = 16'(CLK_DIV - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   // Synchronizer and edge detector
   logic sync1_q;
   logic rx_s_q;
   logic rx_s_d_q;

   // Receive FSM
   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        busy_q;
   logic        push;
   logic        fe_set;

   // FIFO
   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               pop;
   logic               full;
   logic               wr_en;
   logic               ovr_set;

   // Sticky flags
   logic ovr_q, ovr_d;
   logic fe_q, fe_d;

   // ---------------------------------------------------------------------------
   // Receive FSM: every decision uses the synchronized line rx_s_q only.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      push    = 1'b0;
      fe_set  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_s_d_q && !rx_s_q) begin
               // Half a bit lands the start-bit sample in the bit centre.
               cnt_d   = HALF_BIT;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == 16'd0) begin
               if (!rx_s_q) begin
                  cnt_d   = FULL_BIT;
                  idx_d   = 3'd0;
                  state_d = S_DATA;
               end else begin
                  // Line went back high before mid-start: a glitch.
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_q == 16'd0) begin
               shift_d[idx_q] = rx_s_q;
               cnt_d          = FULL_BIT;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == 16'd0) begin
               if (rx_s_q) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  fe_set  = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_WAIT_HIGH: begin
            // A held-low line (break) must not start a new frame.
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FIFO control.  A pop makes room in the same cycle, so push+pop on a full
   // FIFO is not an overrun.  A pop on an empty FIFO is masked out.
   // ---------------------------------------------------------------------------
   always_comb begin
      pop      = RX_READ && (count_q != '0);
      full     = (count_q == DEPTH_CNT);
      wr_en    = push && (!full || pop);
      ovr_set  = push && full && !pop;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      end
      if (wr_en && !pop) begin
         count_d = count_q + (FIFO_AW+1)'(1);
      end else if (!wr_en && pop) begin
         count_d = count_q - (FIFO_AW+1)'(1);
      end
   end

   // Set has priority over clear.
   always_comb begin
      ovr_d = ovr_q;
      fe_d  = fe_q;
      if (ERR_CLEAR) begin
         ovr_d = 1'b0;
         fe_d  = 1'b0;
      end
      if (ovr_set) begin
         ovr_d = 1'b1;
      end
      if (fe_set) begin
         fe_d = 1'b1;
      end
   end

   always_ff @(posedge CORE_CLK) begin
      if (RST) begin
         sync1_q  <= 1'b1;
         rx_s_q   <= 1'b1;
         rx_s_d_q <= 1'b1;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         busy_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovr_q    <= 1'b0;
         fe_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         sync1_q  <= UART_RX;
         rx_s_q   <= sync1_q;
         rx_s_d_q <= rx_s_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         busy_q   <= (state_d != S_IDLE);
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovr_q    <= ovr_d;
         fe_q     <= fe_d;
         if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
         end
      end
   end

   assign RX_DATA        = mem_q[rd_ptr_q];
   assign RX_VALID       = (count_q != '0);
   assign RX_COUNT       = count_q;
   assign RX_OVERRUN     = ovr_q;
   assign RX_FRAMING_ERR = fe_q;
   assign RX_BUSY        = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo at CLK_DIV=16, FIFO_AW=2.  Frames are
//   driven one cycle at a time on the falling clock edge.  Expected FIFO
//   contents are kept in a queue: a byte is pushed when its stop bit is
//   sampled and popped when the bench reads the DUT.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int CLK_DIV = 16;
   localparam int FIFO_AW = 2;
   localparam int DEPTH   = 4;
   localparam int FRAME   = 10 * CLK_DIV;
   localparam int STOP_C  = CLK_DIV/2 + 9*CLK_DIV + 2;  // negedge before stop-sample edge

   logic             clk = 1'b0;
   logic             rst;
   logic             uart_rx;
   logic             rx_read;
   logic             err_clear;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic [FIFO_AW:0] rx_count;
   logic             rx_overrun;
   logic             rx_framing_err;
   logic             rx_busy;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic       ov_exp = 1'b0;

   uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
      .CORE_CLK       (clk),
      .RST            (rst),
      .UART_RX        (uart_rx),
      .RX_READ        (rx_read),
      .ERR_CLEAR      (err_clear),
      .RX_DATA        (rx_data),
      .RX_VALID       (rx_valid),
      .RX_COUNT       (rx_count),
      .RX_OVERRUN     (rx_overrun),
      .RX_FRAMING_ERR (rx_framing_err),
      .RX_BUSY        (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_count"}, 32'(rx_count), 32'd0);
      chk({tag, "_data"},  32'(rx_data),  32'd0);
      chk({tag, "_ovr"},   32'(rx_overrun), 32'd0);
      chk({tag, "_fe"},    32'(rx_framing_err), 32'd0);
      chk({tag, "_busy"},  32'(rx_busy),  32'd0);
   endtask

   // Drive one 8N1 frame starting at the current negedge.  Options: pop or
   // ERR_CLEAR in the stop-sample cycle, latency check on RX_VALID, and a
   // one-cycle reset at cycle rst_at of the frame (negative = none).
   task automatic send(input logic [7:0] b, input logic stop_v, input bit rd_at_stop,
                       input bit clr_at_stop, input bit check_lat, input int rst_at);
      logic [9:0] frame;
      bit         aborted;
      frame   = {stop_v, b, 1'b0};
      aborted = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
         if (check_lat && c == STOP_C)     chk("valid_before_stop", 32'(rx_valid), 32'd0);
         if (check_lat && c == STOP_C + 1) chk("valid_after_stop",  32'(rx_valid), 32'd1);
         uart_rx   = frame[c / CLK_DIV];
         rx_read   = 1'b0;
         err_clear = 1'b0;
         if (c == STOP_C && !aborted) begin
            if (rd_at_stop) begin
               rx_read = 1'b1;
               chk("pop_at_stop_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (clr_at_stop) err_clear = 1'b1;
            if (stop_v) begin
               if (exp_q.size() < DEPTH) exp_q.push_back(b);
               else                      ov_exp = 1'b1;
            end
         end
         if (rst_at >= 0 && c == rst_at) begin
            rst     = 1'b1;
            aborted = 1'b1;
            exp_q.delete();
            ov_exp  = 1'b0;
         end
         if (rst_at >= 0 && c == rst_at + 1) begin
            rst = 1'b0;
            chk_reset_state("midframe_reset");
         end
         @(negedge clk);
      end
      rx_read   = 1'b0;
      err_clear = 1'b0;
   endtask

   task automatic pop_chk(input string tag);
      chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
      chk({tag, "_data"},  32'(rx_data),  32'(exp_q.pop_front()));
      rx_read = 1'b1;
      @(negedge clk);
      rx_read = 1'b0;
   endtask

   initial begin
      int busy_cnt;
      bit fe_seen;
      bit busy_all;

      rst       = 1'b1;
      uart_rx   = 1'b1;
      rx_read   = 1'b0;
      err_clear = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset_state("reset");
      repeat (4) @(negedge clk);

      // 1: single byte, arrival latency, pop
      send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      chk("t1_count", 32'(rx_count), 32'd1);
      pop_chk("t1_pop");
      chk("t1_valid_after_pop", 32'(rx_valid), 32'd0);
      chk("t1_count_after_pop", 32'(rx_count), 32'd0);

      // 2: five back-to-back bytes into a depth-4 FIFO
      for (int i = 1; i <= 5; i++) begin
         send(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, -1);
      end
      chk("t2_count_full", 32'(rx_count), 32'(exp_q.size()));
      chk("t2_overrun", 32'(rx_overrun), 32'(ov_exp));
      for (int i = 0; i < 4; i++) pop_chk("t2_pop");
      chk("t2_empty", 32'(rx_count), 32'd0);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      ov_exp    = 1'b0;
      chk("t2_ovr_cleared", 32'(rx_overrun), 32'(ov_exp));

      // 3: pop in the same cycle as a push into a full FIFO
      for (int i = 1; i <= 4; i++) begin
         send(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, -1);
      end
      chk("t3_full_before", 32'(rx_count), 32'd4);
      send(8'h05, 1'b1, 1'b1, 1'b0, 1'b0, -1);
      chk("t3_count_kept", 32'(rx_count), 32'(exp_q.size()));
      chk("t3_no_overrun", 32'(rx_overrun), 32'd0);
      for (int i = 0; i < 4; i++) pop_chk("t3_pop");
      chk("t3_empty", 32'(rx_count), 32'd0);

      // 4: bad stop bit followed by a long break; ERR_CLEAR coincides with
      //    the stop sample, so the set must win
      send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      chk("t4_fe_set", 32'(rx_framing_err), 32'd1);
      chk("t4_count", 32'(rx_count), 32'd0);
      chk("t4_busy", 32'(rx_busy), 32'd1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      fe_seen   = 1'b0;
      busy_all  = 1'b1;
      for (int i = 0; i < 40*CLK_DIV; i++) begin
         if (rx_framing_err) fe_seen = 1'b1;
         if (!rx_busy)       busy_all = 1'b0;
         @(negedge clk);
      end
      chk("t4_single_fe", 32'(fe_seen), 32'd0);
      chk("t4_busy_in_break", 32'(busy_all), 32'd1);
      uart_rx = 1'b1;
      repeat (5) @(negedge clk);
      chk("t4_idle_after_break", 32'(rx_busy), 32'd0);
      chk("t4_fe_still_clear", 32'(rx_framing_err), 32'd0);
      send(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      chk("t4_count_7e", 32'(rx_count), 32'd1);
      pop_chk("t4_pop");

      // 5: 4-cycle low glitch
      busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         uart_rx = (i < 4) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (rx_busy) busy_cnt++;
      end
      chk("t5_busy_len_ok", 32'((busy_cnt >= 1) && (busy_cnt <= 10)), 32'd1);
      chk("t5_count", 32'(rx_count), 32'd0);
      chk("t5_fe", 32'(rx_framing_err), 32'd0);
      chk("t5_ovr", 32'(rx_overrun), 32'd0);
      chk("t5_busy_end", 32'(rx_busy), 32'd0);

      // 6: reset in the middle of data bit 5 with a byte already queued
      send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      chk("t6_pre_count", 32'(rx_count), 32'd1);
      send(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 6*CLK_DIV + CLK_DIV/2);
      chk("t6_no_partial", 32'(rx_count), 32'd0);
      send(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      chk("t6_count_55", 32'(rx_count), 32'(exp_q.size()));
      pop_chk("t6_pop");
      chk("t6_empty", 32'(rx_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
